d_memory_be: RTL

//  Parametrised single-port data memory for the lab CPU datapath; successor to the

---
 rtl/d_memory_be.sv | 139 +++++++++++++
 1 files changed

// File: rtl/d_memory_be.sv
// d_memory_be: single-port data memory with byte-lane write enables.
//
// After every reset a built-in sequencer zeroes words 0..DEPTH-1, one per
// cycle, holding busy high meanwhile; accesses presented while busy are
// ignored. Once ready, writes update only the lanes selected by byte_en.
// Reads return the registered word one cycle after read_en. A read and a
// write to the same address in one cycle return the merged (write-first)
// word. Accesses to address >= DEPTH never touch memory: reads return zero
// and addr_err pulses for one cycle.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset, restarts the clear sequence
//   write_en  write request
//   read_en   read request
//   address   word address for read and write
//   data_in   write data
//   byte_en   per-byte write mask, bit i covers data_in[8i+7:8i]
//   data_out  registered read data
//   busy      high while the clear sequence runs
//   addr_err  one-cycle pulse for an accepted access with address >= DEPTH
module d_memory_be #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 8,
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic               read_en,
  input  logic [ASIZE-1:0]   address,
  input  logic [DSIZE-1:0]   data_in,
  input  logic [DSIZE/8-1:0] byte_en,
  output logic [DSIZE-1:0]   data_out,
  output logic               busy,
  output logic               addr_err
);

  localparam int NBYTE = DSIZE / 8;
  localparam logic [ASIZE-1:0] LAST_WORD = ASIZE'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ASIZE still compares correctly.
  localparam logic [ASIZE:0]   DEPTH_W   = (ASIZE + 1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_reg;
  logic [ASIZE-1:0] clr_ptr_reg;

  logic [DSIZE-1:0] mem [DEPTH];

  logic             in_range;
  logic             accept;
  logic [DSIZE-1:0] rd_word;
  logic [DSIZE-1:0] merged_word;

  logic             mem_we;
  logic [ASIZE-1:0] mem_addr;
  logic [NBYTE-1:0] mem_mask;
  logic [DSIZE-1:0] mem_wdata;

  assign in_range = ({1'b0, address} < DEPTH_W);
  assign accept   = (state_reg == READY) && (write_en || read_en);
  // Out-of-range reads must never alias onto a real word.
  assign rd_word  = in_range ? mem[address] : '0;

  // Write-first view of the addressed word: new bytes where this cycle's
  // write enables a lane, stored bytes elsewhere.
  generate
    for (genvar gi = 0; gi < NBYTE; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = (write_en && byte_en[gi]) ?
                                      data_in[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  // Single write port shared by the clear sequencer and normal writes.
  // Nothing is written in the rst cycle itself.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_mask  = byte_en;
    mem_wdata = data_in;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_reg;
        mem_mask  = '1;
        mem_wdata = '0;
      end else if (state_reg == READY && write_en && in_range) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (mem_mask[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      data_out    <= '0;
      busy        <= 1'b1;
      addr_err    <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          data_out <= '0;
          addr_err <= 1'b0;
          if (clr_ptr_reg == LAST_WORD) begin
            state_reg   <= READY;
            busy        <= 1'b0;
            clr_ptr_reg <= '0;
          end else begin
            clr_ptr_reg <= clr_ptr_reg + 1'b1;
          end
        end
        READY: begin
          addr_err <= accept && !in_range;
          if (read_en) begin
            data_out <= in_range ? merged_word : '0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          busy      <= 1'b1;
          addr_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
